fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: pc  input  16  current program-counter value from the pc block.
REQ-004 SHALL have ports: inc, add, sub  output  1 each  one-cycle PC update strobes to the pc block.
REQ-005 SHALL have port: offset  output  16  PC offset for add/sub; 16'h0000 whenever add and sub are both low.
REQ-006 SHALL have ports: mem_rd  output  1, mem_addr  output  16  instruction-memory read request and address.
REQ-007 SHALL have ports: mem_ready  input  1, mem_data  input  16  read completion and returned word.
REQ-008 SHALL have ports: instr  output  16, instr_valid  output  1, instr_ack  input  1  downstream instruction handshake.
REQ-009 SHALL have ports: halted  output  1, icount  output  16  halt flag and count of accepted instructions.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, ISSUE, UPDATE, HALT.
REQ-011 IDLE SHALL last exactly one cycle, then go to FETCH.
REQ-012 In FETCH: mem_rd=1 and mem_addr=pc; held stable until mem_ready=1.
REQ-013 On a FETCH cycle with mem_ready=1: mem_data SHALL be latched into instr and the state SHALL go to ISSUE.
REQ-014 In ISSUE: instr_valid=1 and instr held stable until instr_ack=1; an instr_ack outside ISSUE SHALL be ignored.
REQ-015 The ISSUE cycle with instr_ack=1 SHALL increment icount (modulo 2^16, FFFF->0000), then select the next state by opcode instr[15:12].
REQ-016 Opcode 4'hF (HALT) SHALL go to HALT with no PC strobe.
REQ-017 For any other opcode, the next state SHALL be UPDATE.
REQ-018 UPDATE SHALL last exactly one cycle, then go to FETCH.
REQ-019 UPDATE with opcode 4'hC (branch forward): add=1, offset={4'h0, instr[11:0]}.
REQ-020 UPDATE with opcode 4'hD (branch backward): sub=1, offset={4'h0, instr[11:0]}.
REQ-021 UPDATE with any other non-HALT opcode: inc=1, offset=16'h0000.
REQ-022 At most one of inc/add/sub SHALL be high in any cycle; all three SHALL be low outside UPDATE.
REQ-023 The new pc is valid in the FETCH cycle after UPDATE; mem_addr SHALL never show a pre-update pc after an UPDATE.
REQ-024 A branch with offset 0 SHALL still issue a one-cycle add (or sub) strobe, refetching the same address.
REQ-025 PC wrap-around (FFFF+1, 0000-1) is the pc block's concern; fetch_ctrl SHALL not detect or block it.
REQ-026 HALT SHALL be absorbing until reset: halted=1, mem_rd=0, instr_valid=0, no strobes.
REQ-027 mem_ready in a non-FETCH state SHALL be ignored.

Reset
REQ-028 While reset=1: state=IDLE, instr=0000, icount=0000, and every output SHALL be 0.
REQ-029 Reset asserted mid-operation (any state, including during a pending fetch or issue) SHALL abandon the transaction immediately with no strobe emitted.
REQ-030 After reset release: IDLE for one cycle, then FETCH.

Structure
REQ-031 Package fetch_pkg SHALL hold the state encoding, opcode constants (OP_BRF=4'hC, OP_BRB=4'hD, OP_HALT=4'hF) and the 12-bit branch field width.
REQ-032 SHALL contain one combinational sub-module fetch_decode (opcode -> inc/add/sub select, zero-extended offset); the FSM and registers SHALL stay in fetch_ctrl.

Verification
REQ-033 Scenario: reset release with pc=0000, mem_ready=1 the cycle after mem_rd, data=0x1234, ack immediate -> mem_addr=0000; instr=1234; one inc pulse with offset=0000; icount=1.
REQ-034 Scenario: data=0xC005 at pc=0010 -> add=1 with offset=0005 for exactly one cycle; next fetch mem_addr=0015.
REQ-035 Scenario: data=0xD003 at pc=0020 -> sub=1 with offset=0003; next mem_addr=001D.
REQ-036 Scenario: mem_ready delayed 3 cycles, instr_ack delayed 2 cycles -> mem_rd/mem_addr and instr/instr_valid stable throughout; icount increments once.
REQ-037 Scenario: data=0xF000 -> halted=1, no strobe, mem_rd stays 0 for 10+ cycles; a later reset -> IDLE, halted=0.
REQ-038 Scenario: reset asserted while in ISSUE, and again with icount=FFFF -> outputs 0 asynchronously; separately an ack at icount=FFFF -> icount=0000.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared state encoding, opcode constants and branch-field
//                width for the instruction fetch controller.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Width of the unsigned branch displacement carried in instr[11:0]
  localparam int BR_W = 12;

  // Opcodes with special meaning to the fetch controller
  localparam logic [3:0] OP_BRF  = 4'hC;
  localparam logic [3:0] OP_BRB  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Controller state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Opcode field of an instruction word
  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode
//  Description : Combinational opcode decode. Selects which PC update strobe
//                an instruction needs and forms the zero-extended branch
//                offset (zero for anything that is not a branch).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_decode
  import fetch_pkg::*;
(
  input  logic [15:0] instr,
  output logic        sel_inc,
  output logic        sel_add,
  output logic        sel_sub,
  output logic        is_halt,
  output logic [15:0] offset
);

  logic [3:0] w_op;

  assign w_op = opcode_of(instr);

  // Opcode to strobe select; a HALT selects no strobe at all
  always_comb begin
    sel_inc = 1'b0;
    sel_add = 1'b0;
    sel_sub = 1'b0;
    is_halt = 1'b0;
    offset  = 16'h0000;
    case (w_op)
      OP_BRF: begin
        sel_add = 1'b1;
        offset  = {{(16 - BR_W){1'b0}}, instr[BR_W-1:0]};
      end
      OP_BRB: begin
        sel_sub = 1'b1;
        offset  = {{(16 - BR_W){1'b0}}, instr[BR_W-1:0]};
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        sel_inc = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction fetch controller. Reads a word at pc, hands it
//                downstream with a valid/ack handshake, counts accepted
//                instructions and pulses one PC update strobe per
//                instruction. A HALT opcode parks the controller until reset.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        inc,
  output logic        add,
  output logic        sub,
  output logic [15:0] offset,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic        halted,
  output logic [15:0] icount
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_instr;
  logic [15:0] r_icount;

  logic        w_sel_inc;
  logic        w_sel_add;
  logic        w_sel_sub;
  logic        w_is_halt;
  logic [15:0] w_offset;

  // Decode always looks at the latched word, which is stable from ISSUE on
  fetch_decode u_decode (
    .instr   (r_instr),
    .sel_inc (w_sel_inc),
    .sel_add (w_sel_add),
    .sel_sub (w_sel_sub),
    .is_halt (w_is_halt),
    .offset  (w_offset)
  );

  // State register; reset drops straight to IDLE so every output clears at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Capture the fetched word only on the completing FETCH cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= 16'h0000;
    end else if (r_state == ST_FETCH && mem_ready) begin
      r_instr <= mem_data;
    end
  end

  // Count accepted instructions; wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_icount <= 16'h0000;
    end else if (r_state == ST_ISSUE && instr_ack) begin
      r_icount <= r_icount + 16'h0001;
    end
  end

  // Next-state logic and Moore outputs; strobes only ever come from UPDATE
  always_comb begin
    w_next_state = r_state;
    inc          = 1'b0;
    add          = 1'b0;
    sub          = 1'b0;
    offset       = 16'h0000;
    mem_rd       = 1'b0;
    mem_addr     = 16'h0000;
    instr_valid  = 1'b0;
    halted       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
          w_next_state = w_is_halt ? ST_HALT : ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        inc          = w_sel_inc;
        add          = w_sel_add;
        sub          = w_sel_sub;
        offset       = w_offset;
        w_next_state = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign instr  = r_instr;
  assign icount = r_icount;

endmodule
`default_nettype wire
